instruction_fetch: RTL and testbench

- Upstream neighbour of instruction_decoder.
- Holds the program counter and issues single-outstanding word reads to instruction memory.
- Buffers returned 32-bit instruction words in a small FIFO and presents them to the decoder over a valid/ready handshake.
- Accepts a redirect (branch/jump) that flushes buffered and in-flight instructions.

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_sync_fifo.sv | 55 +++++
 rtl/instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: default widths, the NOP word and the fetch FSM encodings.
// Shared with instruction_decoder so both stages agree on the instruction word width.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 8;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

`ifdef ACE_FETCH_STATS_EN
  localparam int unsigned STAT_W = 16;
`endif

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_FETCH   = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_sync_fifo.sv
// Synchronous FIFO holding {pc, instruction} prefetch entries; flush empties it in one edge.
// DEPTH must be a power of two so the pointers wrap naturally.
module instruction_fetch_sync_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; flush discards everything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, single-outstanding memory reads, prefetch FIFO and redirect flush.
// Optional ACE_FETCH_STATS_EN adds saturating fetch_count / stall_count outputs.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ADDR_W,
  parameter int unsigned           INSTR_WIDTH = INSTR_W,
  parameter int unsigned           FIFO_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc
`ifdef ACE_FETCH_STATS_EN
  ,
  output logic [STAT_W-1:0]      fetch_count,
  output logic [STAT_W-1:0]      stall_count
`endif
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + INSTR_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state, state_nx;
  logic [ADDR_WIDTH-1:0]  pc, pc_nx, addr_nx;
  logic                   req_nx;
  logic                   push, pop, full, empty;
  logic [CNT_W-1:0]       count;
  logic [ENTRY_W-1:0]     head;
  logic                   xfer, space_now, space_after_push;

  assign pop              = ~empty & instr_ready;
  assign xfer             = mem_req & mem_ack;
  assign space_now        = ~full | pop;
  assign space_after_push = (count - CNT_W'(pop) + CNT_W'(1)) < CNT_W'(FIFO_DEPTH);

  // Next-state: redirect overrides everything; a request in flight is never dropped.
  always_comb begin
    state_nx = state;
    req_nx   = mem_req;
    addr_nx  = mem_addr;
    pc_nx    = pc;
    push     = 1'b0;
    if (redirect_valid) begin
      pc_nx = redirect_pc;
      case (state)
        FETCH_IDLE: begin
          state_nx = FETCH_FETCH;
          req_nx   = 1'b1;
          addr_nx  = redirect_pc;
        end
        FETCH_FETCH: begin
          if (xfer) begin
            state_nx = FETCH_FETCH;
            addr_nx  = redirect_pc;
          end else begin
            state_nx = FETCH_DISCARD;
          end
        end
        default: state_nx = FETCH_DISCARD;
      endcase
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (space_now) begin
            state_nx = FETCH_FETCH;
            req_nx   = 1'b1;
            addr_nx  = pc;
          end
        end
        FETCH_FETCH: begin
          if (xfer) begin
            push    = 1'b1;
            pc_nx   = pc + ADDR_WIDTH'(1);
            addr_nx = pc + ADDR_WIDTH'(1);
            if (!space_after_push) begin
              state_nx = FETCH_IDLE;
              req_nx   = 1'b0;
            end
          end
        end
        FETCH_DISCARD: begin
          if (xfer) begin
            state_nx = FETCH_FETCH;
            addr_nx  = pc;
          end
        end
        default: begin
          state_nx = FETCH_IDLE;
          req_nx   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FETCH_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      pc       <= RESET_PC;
    end else begin
      state    <= state_nx;
      mem_req  <= req_nx;
      mem_addr <= addr_nx;
      pc       <= pc_nx;
    end
  end

  instruction_fetch_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc, mem_rdata}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Empty buffer presents zeros rather than stale storage.
  assign instr_valid = ~empty;
  assign instr_pc    = empty ? '0 : head[ENTRY_W-1 -: ADDR_WIDTH];
  assign instr_data  = empty ? INSTR_WIDTH'(NOP_WORD) : head[INSTR_WIDTH-1:0];

`ifdef ACE_FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (pop && (fetch_count != '1))  fetch_count <= fetch_count + STAT_W'(1);
      if (empty && (stall_count != '1)) stall_count <= stall_count + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected {pc, word} pushed per scenario, popped on delivery.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [7:0]  instr_pc;
`ifdef ACE_FETCH_STATS_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;
  int   n;

  always #5 clk = ~clk;

  // Memory model: word[a] = 0x0100_0000 + a.
  assign mem_rdata = 32'h0100_0000 + {24'd0, mem_addr};

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef ACE_FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a);
    exp_t e;
    e.pc   = a;
    e.data = 32'h0100_0000 + {24'd0, a};
    exp_q.push_back(e);
  endtask

  task automatic push_run(input logic [7:0] first, input int cnt);
    logic [7:0] a;
    a = first;
    for (int i = 0; i < cnt; i++) begin
      push_exp(a);
      a = a + 8'd1;
    end
  endtask

  task automatic drain(input string tag, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 60) begin
      tick();
      cyc++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    instr_ready    = 1'b0;
    mem_ack        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    tick();
    tick();
    exp_q.delete();
  endtask

  // Delivery monitor and transfer counter, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      xfer_cnt = 0;
    end else begin
      if (mem_req && mem_ack) xfer_cnt++;
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("instr_pc", 64'(instr_pc), 64'(mon_e.pc));
          check("instr_data", 64'(instr_data), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr_data", 64'(instr_data), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);

    // Linear fetch, one per cycle.
    push_run(8'h00, 8);
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    reset = 1'b0;
    tick();
    check("lin_first_req", 64'(mem_req), 64'd1);
    check("lin_first_addr", 64'(mem_addr), 64'd0);
    check("lin_valid_before_xfer", 64'(instr_valid), 64'd0);
    tick();
    check("lin_valid_after_xfer", 64'(instr_valid), 64'd1);
    drain("lin_drain", n);
    check("lin_throughput_cycles", 64'(n), 64'd8);

    // Back-pressure: exactly FIFO_DEPTH transfers, then idle.
    do_reset();
    mem_ack = 1'b1;
    reset = 1'b0;
    repeat (10) tick();
    check("bp_xfer_count", 64'(xfer_cnt), 64'd4);
    check("bp_mem_req_low", 64'(mem_req), 64'd0);
    check("bp_head_pc", 64'(instr_pc), 64'd0);
    push_run(8'h00, 8);
    instr_ready = 1'b1;
    drain("bp_drain", n);

    // Redirect while a request is outstanding.
    do_reset();
    instr_ready = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    redirect_pc = 8'h40;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("disc_req_held", 64'(mem_req), 64'd1);
    check("disc_addr_held", 64'(mem_addr), 64'd0);
    tick();
    mem_ack = 1'b1;
    tick();
    check("disc_new_addr", 64'(mem_addr), 64'h40);
    check("disc_no_stale", 64'(instr_valid), 64'd0);
    push_run(8'h40, 4);
    drain("disc_drain", n);

    // Redirect coincident with a transfer and a pop.
    do_reset();
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    check("coin_valid", 64'(instr_valid), 64'd1);
    push_exp(8'h00);
    redirect_pc = 8'h80;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("coin_flushed", 64'(instr_valid), 64'd0);
    check("coin_addr", 64'(mem_addr), 64'h80);
    check("coin_req", 64'(mem_req), 64'd1);
    push_run(8'h80, 3);
    drain("coin_drain", n);

    // Address wrap-around.
    do_reset();
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    redirect_pc = 8'hFE;
    redirect_valid = 1'b1;
    reset = 1'b0;
    push_run(8'hFE, 5);
    tick();
    redirect_valid = 1'b0;
    check("wrap_addr", 64'(mem_addr), 64'hFE);
    drain("wrap_drain", n);

    // Async reset mid-FETCH.
    do_reset();
    mem_ack = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("ar_pre_req", 64'(mem_req), 64'd1);
    check("ar_pre_valid", 64'(instr_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_req_drop", 64'(mem_req), 64'd0);
    check("ar_valid_drop", 64'(instr_valid), 64'd0);
    check("ar_addr_reset", 64'(mem_addr), 64'd0);
    do_reset();
    mem_ack = 1'b1;
    instr_ready = 1'b1;
    push_run(8'h00, 4);
    reset = 1'b0;
    tick();
    check("ar_restart_addr", 64'(mem_addr), 64'd0);
    drain("ar_drain", n);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
